// File: rtl/lsu_hs_pkg.sv
// Shared types and constants for the load/store handshake unit.
package lsu_hs_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } lsu_state_t;

  localparam logic [1:0] LSU_B = 2'd0;
  localparam logic [1:0] LSU_H = 2'd1;
  localparam logic [1:0] LSU_W = 2'd2;
  localparam logic [1:0] LSU_D = 2'd3;

  localparam int F3_UNSIGNED = 2;

  function automatic int size_bytes(input logic [1:0] size);
    return 1 << size;
  endfunction

endpackage

// File: rtl/lsu_hs_align.sv
// Byte-lane steering: store byte enables / data shift and load shift / extension.
module lsu_hs_align
  import lsu_hs_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [$clog2(XLEN/8)-1:0] i_st_off,
  input  logic [1:0]                i_st_size,
  input  logic [XLEN-1:0]           i_st_data,
  output logic [XLEN/8-1:0]         o_be,
  output logic [XLEN-1:0]           o_st_data,
  input  logic [$clog2(XLEN/8)-1:0] i_ld_off,
  input  logic [2:0]                i_ld_funct3,
  input  logic [XLEN-1:0]           i_ld_data,
  output logic [XLEN-1:0]           o_ld_data
);

  localparam int NB = XLEN / 8;

  logic [NB-1:0]   w_len_mask;
  logic [XLEN-1:0] w_ld_shr;
  logic            w_msb;
  logic            w_ext;
  int              w_nbits;

  always_comb begin
    w_len_mask = '0;
    for (int j = 0; j < NB; j++) begin
      w_len_mask[j] = (j < size_bytes(i_st_size));
    end
    o_be      = w_len_mask << i_st_off;
    o_st_data = i_st_data << {i_st_off, 3'b000};
  end

  always_comb begin
    w_ld_shr = i_ld_data >> {i_ld_off, 3'b000};
    w_nbits  = 8 * size_bytes(i_ld_funct3[1:0]);
    w_msb    = 1'b0;
    case (i_ld_funct3[1:0])
      LSU_B: w_msb = w_ld_shr[7];
      LSU_H: w_msb = w_ld_shr[15];
      LSU_W: w_msb = w_ld_shr[31];
      LSU_D: w_msb = w_ld_shr[XLEN-1];
      default: w_msb = 1'b0;
    endcase
    w_ext     = w_msb & ~i_ld_funct3[F3_UNSIGNED];
    o_ld_data = '0;
    // Bits above the access size take the extension bit.
    for (int i = 0; i < XLEN; i++) begin
      o_ld_data[i] = (i < w_nbits) ? w_ld_shr[i] : w_ext;
    end
  end

endmodule

// File: rtl/lsu_hs.sv
// Load/store unit: request/grant/response handshake to data memory with
// alignment checking, lane steering, load extension and bus timeout.
//   state  | meaning
//   S_IDLE | waiting for a memory op from EX-MEM
//   S_REQ  | o_mem_req held until granted
//   S_WAIT | granted, waiting for i_mem_rvalid
//   S_RESP | one-cycle completion: o_done, o_rdata, o_bus_err
module lsu_hs
  import lsu_hs_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_valid,
  input  logic              i_read,
  input  logic              i_write,
  input  logic [2:0]        i_funct3,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [XLEN-1:0]   i_wdata,
  output logic              o_stall,
  output logic [XLEN-1:0]   o_rdata,
  output logic              o_done,
  output logic              o_misaligned,
  output logic              o_bus_err,
  output logic              o_mem_req,
  input  logic              i_mem_gnt,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [XLEN/8-1:0] o_mem_be,
  output logic [XLEN-1:0]   o_mem_wdata,
  input  logic              i_mem_rvalid,
  input  logic [XLEN-1:0]   i_mem_rdata,
  input  logic              i_mem_err
);

  localparam int NB      = XLEN / 8;
  localparam int OFF_W   = $clog2(NB);
  localparam int CNT_W   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam int TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  lsu_state_t        r_state;
  lsu_state_t        w_state_nxt;

  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [NB-1:0]     r_be;
  logic [XLEN-1:0]   r_wdata;
  logic [XLEN-1:0]   r_rdata;
  logic [2:0]        r_funct3;
  logic [OFF_W-1:0]  r_off;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_err;

  logic              w_op;
  logic [OFF_W-1:0]  w_off;
  logic              w_illegal;
  logic              w_misal;
  logic              w_accept;
  logic              w_timeout;
  logic [NB-1:0]     w_be;
  logic [XLEN-1:0]   w_wdata_sh;
  logic [XLEN-1:0]   w_ld_fmt;

  assign w_op      = i_valid & (i_read | i_write);
  assign w_off     = i_addr[OFF_W-1:0];
  assign w_illegal = (int'(i_funct3[1:0]) > OFF_W);
  assign w_misal   = |(w_off & OFF_W'(size_bytes(i_funct3[1:0]) - 1));
  assign w_accept  = (r_state == S_IDLE) && w_op && !w_illegal && !w_misal;
  // Fires on the TIMEOUT-th cycle spent in REQ/WAIT; TIMEOUT=0 never fires.
  assign w_timeout = (TIMEOUT != 0) && (r_cnt == CNT_W'(TO_LAST));

  lsu_hs_align #(
    .XLEN (XLEN)
  ) u_align (
    .i_st_off    (w_off),
    .i_st_size   (i_funct3[1:0]),
    .i_st_data   (i_wdata),
    .o_be        (w_be),
    .o_st_data   (w_wdata_sh),
    .i_ld_off    (r_off),
    .i_ld_funct3 (r_funct3),
    .i_ld_data   (i_mem_rdata),
    .o_ld_data   (w_ld_fmt)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    o_stall      = 1'b0;
    o_done       = 1'b0;
    o_misaligned = 1'b0;
    o_bus_err    = 1'b0;
    o_mem_req    = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_misaligned = w_op & (w_illegal | w_misal);
        o_stall      = w_accept;
        if (w_accept) w_state_nxt = S_REQ;
      end
      S_REQ: begin
        o_mem_req = 1'b1;
        o_stall   = 1'b1;
        if (w_timeout)      w_state_nxt = S_RESP;
        else if (i_mem_gnt) w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        o_stall = 1'b1;
        if (i_mem_rvalid || w_timeout) w_state_nxt = S_RESP;
      end
      S_RESP: begin
        o_done      = 1'b1;
        o_bus_err   = r_err;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_be     <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_funct3 <= '0;
      r_off    <= '0;
      r_cnt    <= '0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_we     <= i_write;
            r_addr   <= {i_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            r_be     <= w_be;
            r_wdata  <= w_wdata_sh;
            r_funct3 <= i_funct3;
            r_off    <= w_off;
            r_cnt    <= '0;
            r_err    <= 1'b0;
            r_rdata  <= '0;
          end
        end
        S_REQ: begin
          r_cnt <= r_cnt + 1'b1;
          if (w_timeout) r_err <= 1'b1;
        end
        S_WAIT: begin
          r_cnt <= r_cnt + 1'b1;
          // A genuine response on the last allowed cycle beats the timeout.
          if (i_mem_rvalid) begin
            r_rdata <= r_we ? '0 : w_ld_fmt;
            r_err   <= i_mem_err;
          end else if (w_timeout) begin
            r_err <= 1'b1;
          end
        end
        S_RESP: begin
          r_we <= 1'b0;
          r_be <= '0;
        end
        default: ;
      endcase
    end
  end

  assign o_rdata     = r_rdata;
  assign o_mem_we    = r_we;
  assign o_mem_addr  = r_addr;
  assign o_mem_be    = r_be;
  assign o_mem_wdata = r_wdata;

endmodule

// File: tb/tb_lsu_hs.sv
// Directed bench for lsu_hs: a 32-bit instance (TIMEOUT=8) and a 64-bit instance.
module tb_lsu_hs;

  logic        clk;
  logic        rstn;
  logic        v32, v64, rd, wr;
  logic [2:0]  f3;
  logic [31:0] addr;
  logic [63:0] wd;
  logic        gnt, rvalid, merr;
  logic [63:0] mrd;
  logic        sel_r;

  logic        s32_stall, s32_done, s32_mis, s32_berr, s32_req, s32_we;
  logic [31:0] s32_rdata, s32_addr, s32_wdata;
  logic [3:0]  s32_be;
  logic        s64_stall, s64_done, s64_mis, s64_berr, s64_req, s64_we;
  logic [63:0] s64_rdata, s64_wdata;
  logic [31:0] s64_addr;
  logic [7:0]  s64_be;

  logic        x_stall, x_done, x_mis, x_berr, x_req, x_we;
  logic [63:0] x_rdata, x_wdata, x_be, x_addr;

  int errors = 0;
  int checks = 0;

  int          dc, sc;
  logic        mis, rq, we_o, berr_o;
  logic [63:0] be_o, wd_o, ad_o, rd_o;

  lsu_hs #(.XLEN(32), .ADDR_W(32), .TIMEOUT(8)) u_dut32 (
    .clk(clk), .rstn(rstn), .i_valid(v32), .i_read(rd), .i_write(wr),
    .i_funct3(f3), .i_addr(addr), .i_wdata(wd[31:0]),
    .o_stall(s32_stall), .o_rdata(s32_rdata), .o_done(s32_done),
    .o_misaligned(s32_mis), .o_bus_err(s32_berr), .o_mem_req(s32_req),
    .i_mem_gnt(gnt), .o_mem_we(s32_we), .o_mem_addr(s32_addr),
    .o_mem_be(s32_be), .o_mem_wdata(s32_wdata), .i_mem_rvalid(rvalid),
    .i_mem_rdata(mrd[31:0]), .i_mem_err(merr)
  );

  lsu_hs #(.XLEN(64), .ADDR_W(32), .TIMEOUT(16)) u_dut64 (
    .clk(clk), .rstn(rstn), .i_valid(v64), .i_read(rd), .i_write(wr),
    .i_funct3(f3), .i_addr(addr), .i_wdata(wd),
    .o_stall(s64_stall), .o_rdata(s64_rdata), .o_done(s64_done),
    .o_misaligned(s64_mis), .o_bus_err(s64_berr), .o_mem_req(s64_req),
    .i_mem_gnt(gnt), .o_mem_we(s64_we), .o_mem_addr(s64_addr),
    .o_mem_be(s64_be), .o_mem_wdata(s64_wdata), .i_mem_rvalid(rvalid),
    .i_mem_rdata(mrd), .i_mem_err(merr)
  );

  assign x_stall = sel_r ? s64_stall : s32_stall;
  assign x_done  = sel_r ? s64_done  : s32_done;
  assign x_mis   = sel_r ? s64_mis   : s32_mis;
  assign x_berr  = sel_r ? s64_berr  : s32_berr;
  assign x_req   = sel_r ? s64_req   : s32_req;
  assign x_we    = sel_r ? s64_we    : s32_we;
  assign x_rdata = sel_r ? s64_rdata : {32'd0, s32_rdata};
  assign x_wdata = sel_r ? s64_wdata : {32'd0, s32_wdata};
  assign x_be    = sel_r ? {56'd0, s64_be} : {60'd0, s32_be};
  assign x_addr  = sel_r ? {32'd0, s64_addr} : {32'd0, s32_addr};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issues one access on cycle 0 and plays a memory that grants after gd
  // REQ cycles (gd<0: never) and responds the cycle after the grant.
  task automatic run(input logic sel, input logic r, input logic w, input logic [2:0] f,
                     input logic [31:0] a, input logic [63:0] d, input int gd,
                     input logic [63:0] md, input logic me,
                     output int done_c, output int stall_c, output logic mis_o,
                     output logic req_seen, output logic [63:0] be, output logic [63:0] wdo,
                     output logic [63:0] ado, output logic weo, output logic [63:0] rdo,
                     output logic beo);
    int waitc;
    bit pend;
    waitc = 0; pend = 0;
    done_c = -1; req_seen = 1'b0; be = '0; wdo = '0; ado = '0; weo = 1'b0;
    rdo = '0; beo = 1'b0;
    next_cycle();
    sel_r = sel;
    rd = r; wr = w; f3 = f; addr = a; wd = d;
    if (sel) v64 = 1'b1; else v32 = 1'b1;
    #1;
    mis_o   = x_mis;
    stall_c = x_stall ? 1 : 0;
    for (int c = 1; c <= 40; c++) begin
      next_cycle();
      v32 = 1'b0; v64 = 1'b0; gnt = 1'b0; rvalid = 1'b0; merr = 1'b0; mrd = '0;
      if (pend) begin
        rvalid = 1'b1; mrd = md; merr = me; pend = 0;
      end else if (x_req) begin
        if (!req_seen) begin
          be = x_be; wdo = x_wdata; ado = x_addr; weo = x_we;
        end
        req_seen = 1'b1;
        if (waitc == gd) begin
          gnt = 1'b1; pend = 1;
        end else begin
          waitc++;
        end
      end
      #1;
      if (x_stall) stall_c++;
      if (x_done) begin
        done_c = c; rdo = x_rdata; beo = x_berr;
        break;
      end
      if (mis_o && c >= 3) break;
    end
  endtask

  initial begin
    rstn = 1'b0; v32 = 1'b0; v64 = 1'b0; rd = 1'b0; wr = 1'b0; f3 = '0;
    addr = '0; wd = '0; gnt = 1'b0; rvalid = 1'b0; merr = 1'b0; mrd = '0; sel_r = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall",  64'(x_stall), 64'd0);
    chk("rst_done",   64'(x_done),  64'd0);
    chk("rst_req",    64'(x_req),   64'd0);
    chk("rst_be",     x_be,         64'd0);
    chk("rst_rdata",  x_rdata,      64'd0);
    chk("rst_addr",   x_addr,       64'd0);
    rstn = 1'b1;

    // LB 0x1003, zero-wait
    run(1'b0, 1'b1, 1'b0, 3'b000, 32'h1003, 64'd0, 0, 64'h80FF_FF11, 1'b0,
        dc, sc, mis, rq, be_o, wd_o, ad_o, we_o, rd_o, berr_o);
    chk("lb_be",    be_o, 64'h8);
    chk("lb_addr",  ad_o, 64'h1000);
    chk("lb_we",    64'(we_o), 64'd0);
    chk("lb_done",  64'(dc), 64'd3);
    chk("lb_stall", 64'(sc), 64'd3);
    chk("lb_rdata", rd_o, 64'hFFFF_FF80);
    chk("lb_berr",  64'(berr_o), 64'd0);

    // LBU 0x1003
    run(1'b0, 1'b1, 1'b0, 3'b100, 32'h1003, 64'd0, 0, 64'h80FF_FF11, 1'b0,
        dc, sc, mis, rq, be_o, wd_o, ad_o, we_o, rd_o, berr_o);
    chk("lbu_rdata", rd_o, 64'h0000_0080);

    // SH 0x2002, two wait cycles before grant
    run(1'b0, 1'b0, 1'b1, 3'b001, 32'h2002, 64'h0000_BEEF, 2, 64'hFFFF_FFFF, 1'b0,
        dc, sc, mis, rq, be_o, wd_o, ad_o, we_o, rd_o, berr_o);
    chk("sh_be",    be_o, 64'hC);
    chk("sh_wdata", wd_o, 64'hBEEF_0000);
    chk("sh_we",    64'(we_o), 64'd1);
    chk("sh_stall", 64'(sc), 64'd5);
    chk("sh_done",  64'(dc), 64'd5);
    chk("sh_rdata", rd_o, 64'd0);

    // LW 0x3001 misaligned
    run(1'b0, 1'b1, 1'b0, 3'b010, 32'h3001, 64'd0, 0, 64'd0, 1'b0,
        dc, sc, mis, rq, be_o, wd_o, ad_o, we_o, rd_o, berr_o);
    chk("lw_mis",   64'(mis), 64'd1);
    chk("lw_noreq", 64'(rq),  64'd0);
    chk("lw_nostl", 64'(sc),  64'd0);
    chk("lw_nodone", 64'(dc), 64'hFFFF_FFFF_FFFF_FFFF);

    // LD on 32-bit: size exceeds XLEN
    run(1'b0, 1'b1, 1'b0, 3'b011, 32'h2000, 64'd0, 0, 64'd0, 1'b0,
        dc, sc, mis, rq, be_o, wd_o, ad_o, we_o, rd_o, berr_o);
    chk("ld32_mis",   64'(mis), 64'd1);
    chk("ld32_noreq", 64'(rq),  64'd0);

    // Timeout: never granted
    run(1'b0, 1'b1, 1'b0, 3'b010, 32'h44, 64'd0, -1, 64'd0, 1'b0,
        dc, sc, mis, rq, be_o, wd_o, ad_o, we_o, rd_o, berr_o);
    chk("to_done",  64'(dc), 64'd9);
    chk("to_berr",  64'(berr_o), 64'd1);
    chk("to_rdata", rd_o, 64'd0);
    chk("to_stall", 64'(sc), 64'd9);
    next_cycle();
    rvalid = 1'b1; mrd = 64'h1234;
    #1;
    chk("to_late_rvalid", 64'(x_done), 64'd0);
    rvalid = 1'b0; mrd = '0;

    // Access after timeout proceeds normally
    run(1'b0, 1'b1, 1'b0, 3'b010, 32'h40, 64'd0, 0, 64'h1234_5678, 1'b0,
        dc, sc, mis, rq, be_o, wd_o, ad_o, we_o, rd_o, berr_o);
    chk("post_to_done",  64'(dc), 64'd3);
    chk("post_to_rdata", rd_o, 64'h1234_5678);
    chk("post_to_berr",  64'(berr_o), 64'd0);

    // Memory error response
    run(1'b0, 1'b1, 1'b0, 3'b010, 32'h50, 64'd0, 0, 64'h55, 1'b1,
        dc, sc, mis, rq, be_o, wd_o, ad_o, we_o, rd_o, berr_o);
    chk("merr_done", 64'(dc), 64'd3);
    chk("merr_berr", 64'(berr_o), 64'd1);

    // 64-bit: LW 0x104
    run(1'b1, 1'b1, 1'b0, 3'b010, 32'h104, 64'd0, 0, 64'h8000_0001_0000_0000, 1'b0,
        dc, sc, mis, rq, be_o, wd_o, ad_o, we_o, rd_o, berr_o);
    chk("lw64_be",    be_o, 64'hF0);
    chk("lw64_addr",  ad_o, 64'h100);
    chk("lw64_rdata", rd_o, 64'hFFFF_FFFF_8000_0001);

    // 64-bit: LWU 0x104
    run(1'b1, 1'b1, 1'b0, 3'b110, 32'h104, 64'd0, 0, 64'h8000_0001_0000_0000, 1'b0,
        dc, sc, mis, rq, be_o, wd_o, ad_o, we_o, rd_o, berr_o);
    chk("lwu64_rdata", rd_o, 64'h0000_0000_8000_0001);

    // 64-bit: LD 0x108, one wait cycle
    run(1'b1, 1'b1, 1'b0, 3'b011, 32'h108, 64'd0, 1, 64'hDEAD_BEEF_0123_4567, 1'b0,
        dc, sc, mis, rq, be_o, wd_o, ad_o, we_o, rd_o, berr_o);
    chk("ld64_be",    be_o, 64'hFF);
    chk("ld64_done",  64'(dc), 64'd4);
    chk("ld64_rdata", rd_o, 64'hDEAD_BEEF_0123_4567);

    // 64-bit: SB 0x2001
    run(1'b1, 1'b0, 1'b1, 3'b000, 32'h2001, 64'h0000_00AB, 0, 64'hFFFF, 1'b0,
        dc, sc, mis, rq, be_o, wd_o, ad_o, we_o, rd_o, berr_o);
    chk("sb64_be",    be_o, 64'h02);
    chk("sb64_wdata", wd_o, 64'hAB00);
    chk("sb64_addr",  ad_o, 64'h2000);
    chk("sb64_rdata", rd_o, 64'd0);

    // Reset in the middle of WAIT on the 32-bit instance
    next_cycle();
    sel_r = 1'b0;
    v32 = 1'b1; rd = 1'b1; wr = 1'b0; f3 = 3'b010; addr = 32'h10;
    next_cycle();
    v32 = 1'b0; gnt = 1'b1;
    next_cycle();
    gnt = 1'b0;
    #1;
    chk("rstw_pre_stall", 64'(x_stall), 64'd1);
    #2;
    rstn = 1'b0;
    #1;
    chk("rstw_stall", 64'(x_stall), 64'd0);
    chk("rstw_req",   64'(x_req),   64'd0);
    chk("rstw_done",  64'(x_done),  64'd0);
    chk("rstw_be",    x_be,         64'd0);
    chk("rstw_addr",  x_addr,       64'd0);
    next_cycle();
    rstn = 1'b1; rvalid = 1'b1; mrd = 64'hCAFE;
    #1;
    chk("rstw_late0", 64'(x_done), 64'd0);
    next_cycle();
    rvalid = 1'b0; mrd = '0;
    #1;
    chk("rstw_late1", 64'(x_done),  64'd0);
    chk("rstw_idle",  64'(x_stall), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lsu_hs.md
# lsu_hs

Parametrised load/store unit for the pipelined core, sitting between the EX-MEM pipeline register and the data-memory port. It replaces a single-cycle combinational memory stage with a request/grant/response handshake, so data memory may take any number of wait states. It generates byte enables and sign/zero extension for all RISC-V access sizes up to XLEN, detects misalignment and bus timeout, and raises a stall to the hazard unit while an access is outstanding.

## Interface
- XLEN, 32: data width, 32 or 64; sizes B/H/W (and D when 64) supported
- ADDR_W, 32: address width
- TIMEOUT, 64: max cycles in REQ+WAIT before bus error; 0 disables
- clk  in  1  clock; all state rising-edge
- rstn  in  1  reset, asynchronous, active-low
- i_valid  in  1  EX-MEM holds a memory op this cycle
- i_read / i_write  in  1 / 1  load / store; both set treated as store
- i_funct3  in  3  RISC-V load/store funct3; [1:0]=log2 size, [2]=unsigned
- i_addr  in  ADDR_W  byte address
- i_wdata  in  XLEN  store data, LSB-justified
- o_stall  out  1  freeze IF..EX-MEM while busy
- o_rdata  out  XLEN  formatted load result, valid with o_done
- o_done  out  1  one-cycle access-complete pulse
- o_misaligned  out  1  one-cycle pulse, access rejected
- o_bus_err  out  1  one-cycle pulse with o_done on timeout or i_mem_err
- o_mem_req  out  1  request to memory
- i_mem_gnt  in  1  request accepted this cycle
- o_mem_we  out  1  write request
- o_mem_addr  out  ADDR_W  address, aligned down to XLEN/8
- o_mem_be  out  XLEN/8  byte enables
- o_mem_wdata  out  XLEN  lane-shifted store data
- i_mem_rvalid  in  1  response/ack (loads and stores)
- i_mem_rdata  in  XLEN  read data, valid with i_mem_rvalid
- i_mem_err  in  1  error, qualified by i_mem_rvalid

## Operation
- States: IDLE, REQ, WAIT, RESP.
- IDLE: on i_valid and (i_read|i_write): if legal and aligned, latch op/addr/be/wdata/funct3, go REQ, o_stall=1 combinationally this cycle. If misaligned (addr mod size != 0) or size > XLEN/8: o_misaligned=1 this cycle, no request, no stall, stay IDLE.
- REQ: o_mem_req=1 with latched fields held stable; on i_mem_gnt go WAIT.
- WAIT: on i_mem_rvalid capture rdata/err, go RESP. i_mem_rvalid in REQ is ignored.
- RESP: o_done=1, o_stall=0, o_rdata valid, o_bus_err=err; go IDLE. A new access may be accepted next cycle.
- Timeout: counter clears on entering REQ, increments each REQ/WAIT cycle; on reaching TIMEOUT go RESP with o_bus_err=1, o_rdata=0; later rvalid ignored.
- Byte offset off=addr[log2(XLEN/8)-1:0]; be = ((1<<size)-1)<<off; wdata = i_wdata<<(8*off).
- Load: rdata>>(8*off), truncate to size, sign-extend if funct3[2]=0 else zero-extend; stores return o_rdata=0.
- i_valid ignored outside IDLE (upstream is stalled and holds).

## Timing
- Reset: state IDLE, counter 0; o_stall, o_done, o_misaligned, o_bus_err, o_mem_req, o_mem_we, o_mem_be, o_mem_addr, o_mem_wdata, o_rdata all 0.
- Reset mid-access: immediate IDLE, outstanding response dropped (memory is reset together).
- Zero-wait memory (gnt in first REQ cycle, rvalid next cycle): accept cycle 0, REQ 1, WAIT 2, RESP 3; o_stall high cycles 0-2; latency 3 cycles, +1 per wait cycle.
- Memory outputs are registered; no combinational path from i_mem_* to o_mem_*.
- o_stall is combinational from i_valid in IDLE only; otherwise registered-state decode.

## Structure
- core_pkg: lsu_state_t enum; size constants LSU_B=0, LSU_H=1, LSU_W=2, LSU_D=3; funct3 unsigned-bit index.
- Sub-module lsu_align (combinational): be generation, store shift, load shift and extend; parametrised on XLEN.

## Test plan
- Reset: rstn low mid-WAIT -> all outputs 0 immediately, IDLE, later rvalid produces no o_done.
- LB addr 0x1003, zero-wait memory, rdata 0x80FF_FF11 -> be=4'b1000, o_done cycle 3, o_rdata=0xFFFF_FF80; LBU -> 0x0000_0080.
- SH addr 0x2002 wdata 0x0000_BEEF, gnt after 2 wait cycles -> be=4'b1100, o_mem_wdata=0xBEEF_0000, o_stall high 5 cycles.
- LW addr 0x3001 -> o_misaligned pulse, no o_mem_req, no stall; LD with XLEN=32 -> o_misaligned.
- TIMEOUT=8, gnt never -> o_done and o_bus_err on cycle 9, o_rdata=0; next access proceeds.
- XLEN=64, LW addr 0x104, rdata 0x8000_0001_0000_0000 -> be=8'hF0, o_rdata=0xFFFF_FFFF_8000_0001.
